// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID latch, skid buffer for decode stalls and stale-miss dropping.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_npc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HOLD   = 2'b01,
        ST_DROP   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] req_addr_r, req_addr_s;
    logic [31:0] skid_r, skid_s;
    logic        imemren_r, imemren_s;
    logic        valid_r, valid_s;
    logic [31:0] instr_r, instr_s;
    logic [31:0] id_pc_r, id_pc_s;
    logic [31:0] id_npc_r, id_npc_s;
    logic        ld_valid_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] redirect_tgt_s;

    assign pc_plus4_s     = pc_r + 32'd4;
    assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;

    assign imemREN     = imemren_r;
    assign imemaddr    = req_addr_r;
    assign if_id_valid = valid_r;
    assign if_id_instr = instr_r;
    assign if_id_pc    = id_pc_r;
    assign if_id_npc   = id_npc_r;

    // Next-state, PC and IF/ID latch selection
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        req_addr_s = req_addr_r;
        skid_s     = skid_r;
        valid_s    = valid_r;
        instr_s    = instr_r;
        id_pc_s    = id_pc_r;
        id_npc_s   = id_npc_r;
        ld_valid_s = 1'b0;

        if ((state_r == ST_HALTED) || halt) begin
            state_s = ST_HALTED;
            valid_s = 1'b0;
            instr_s = NOP_INSTR;
        end else if (redirect) begin
            // Flush: anything returned or captured this cycle belongs to the wrong path
            valid_s = 1'b0;
            instr_s = NOP_INSTR;
            pc_s    = redirect_tgt_s;
            case (state_r)
                ST_RUN: begin
                    if (ihit) begin
                        req_addr_s = redirect_tgt_s;
                        state_s    = ST_RUN;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                ST_HOLD: begin
                    req_addr_s = redirect_tgt_s;
                    state_s    = ST_RUN;
                end
                ST_DROP: begin
                    state_s = ST_DROP;
                end
                default: begin
                    state_s = ST_HALTED;
                end
            endcase
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (ihit) begin
                        if (if_id_write) begin
                            valid_s    = 1'b1;
                            instr_s    = imemload;
                            id_pc_s    = pc_r;
                            id_npc_s   = pc_plus4_s;
                            ld_valid_s = 1'b1;
                            if (pc_write) begin
                                pc_s       = pc_plus4_s;
                                req_addr_s = pc_plus4_s;
                            end else begin
                                pc_s = pc_r;
                            end
                        end else begin
                            skid_s  = imemload;
                            state_s = ST_HOLD;
                        end
                    end else begin
                        if (if_id_write) begin
                            valid_s = 1'b0;
                            instr_s = NOP_INSTR;
                        end else begin
                            valid_s = valid_r;
                        end
                    end
                end
                ST_HOLD: begin
                    if (if_id_write) begin
                        valid_s    = 1'b1;
                        instr_s    = skid_r;
                        id_pc_s    = pc_r;
                        id_npc_s   = pc_plus4_s;
                        ld_valid_s = 1'b1;
                        state_s    = ST_RUN;
                        if (pc_write) begin
                            pc_s       = pc_plus4_s;
                            req_addr_s = pc_plus4_s;
                        end else begin
                            req_addr_s = pc_r;
                        end
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_DROP: begin
                    valid_s = 1'b0;
                    instr_s = NOP_INSTR;
                    if (ihit) begin
                        req_addr_s = pc_r;
                        state_s    = ST_RUN;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                default: begin
                    state_s = ST_HALTED;
                    valid_s = 1'b0;
                    instr_s = NOP_INSTR;
                end
            endcase
        end

        imemren_s = (state_s == ST_RUN) || (state_s == ST_DROP);
    end

    // State, PC, request address, skid buffer and IF/ID registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            req_addr_r <= RESET_PC;
            skid_r     <= 32'h0000_0000;
            imemren_r  <= 1'b1;
            valid_r    <= 1'b0;
            instr_r    <= NOP_INSTR;
            id_pc_r    <= 32'h0000_0000;
            id_npc_r   <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            req_addr_r <= req_addr_s;
            skid_r     <= skid_s;
            imemren_r  <= imemren_s;
            valid_r    <= valid_s;
            instr_r    <= instr_s;
            id_pc_r    <= id_pc_s;
            id_npc_r   <= id_npc_s;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_r;
    logic [31:0] stall_count_r;
    logic        stall_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    assign stall_s = (state_r == ST_HOLD) || (state_r == ST_DROP) ||
                     ((state_r == ST_RUN) && !ihit);

    assign fetch_count = fetch_count_r;
    assign stall_count = stall_count_r;

    // Saturating fetch and stall counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_count_r <= 32'h0000_0000;
            stall_count_r <= 32'h0000_0000;
        end else begin
            fetch_count_r <= ld_valid_s ? sat_inc(fetch_count_r) : fetch_count_r;
            stall_count_r <= stall_s ? sat_inc(stall_count_r) : stall_count_r;
        end
    end
`else
    logic unused_perf_s;
    assign unused_perf_s = ld_valid_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/miss/redirect traffic,
// checked by a scoreboard holding the architectural fetch path.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        pc_write;
    logic        if_id_write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_npc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_npc(if_id_npc)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_deliv = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tail_pc;
    bit          halted_m = 1'b0;
    bit          last_ifw = 1'b0;

    // Program memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 4) begin
            tail_pc = tail_pc + 32'd4;
            exp_q.push_back(tail_pc);
        end
    endtask

    // The architectural path restarts at a new address; everything in flight is forgotten
    task automatic new_path(input logic [31:0] start);
        exp_q.delete();
        exp_q.push_back(start);
        tail_pc = start;
        refill();
    endtask

    // One clock of stimulus; the memory answers only while a read is requested
    task automatic cycle(input bit want_hit, input bit wr, input bit rd,
                         input logic [31:0] rpc, input bit hl);
        ihit        = want_hit & imemREN;
        imemload    = ihit ? mem_word(imemaddr) : $urandom();
        pc_write    = wr;
        if_id_write = wr;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        @(posedge CLK);
        if (RST) begin
            halted_m = 1'b0;
            last_ifw = 1'b0;
            new_path(RESET_PC);
        end else if (!halted_m) begin
            if (hl) begin
                halted_m = 1'b1;
            end else if (rd) begin
                new_path(rpc & 32'hFFFF_FFFC);
            end
            last_ifw = wr;
        end
        refill();
        #1;
    endtask

    // Monitor: every fresh valid IF/ID load must be the next instruction on the path
    always @(negedge CLK) begin
        logic [31:0] p;
        if (halted_m) begin
            check32("halted_valid", {31'd0, if_id_valid}, 32'd0);
            check32("halted_ren", {31'd0, imemREN}, 32'd0);
        end else if (last_ifw && if_id_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard_empty: got pc %h expected none", if_id_pc);
            end else begin
                p = exp_q.pop_front();
                check32("ifid_pc", if_id_pc, p);
                check32("ifid_npc", if_id_npc, p + 32'd4);
                check32("ifid_instr", if_id_instr, mem_word(p));
                n_deliv++;
            end
        end
    end

    initial begin
        RST = 1'b1; ihit = 1'b0; imemload = 32'd0; pc_write = 1'b0; if_id_write = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
        tail_pc = RESET_PC;
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        check32("rst_ren", {31'd0, imemREN}, 32'd1);
        check32("rst_addr", imemaddr, RESET_PC);
        check32("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check32("rst_instr", if_id_instr, NOP_INSTR);
        check32("rst_pc", if_id_pc, 32'd0);
        check32("rst_npc", if_id_npc, 32'd0);
        RST = 1'b0;

        // Straight-line fetch
        for (int i = 0; i < 4; i++) begin
            check32("seq_addr", imemaddr, 32'(i * 4));
            cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        end
        check32("seq_addr", imemaddr, 32'h10);

        // Redirect while the miss at 0x10 is outstanding
        cycle(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
        check32("drop_ren", {31'd0, imemREN}, 32'd1);
        check32("drop_addr_held", imemaddr, 32'h10);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check32("drop_stale_valid", {31'd0, if_id_valid}, 32'd0);
        check32("drop_exit_addr", imemaddr, 32'h40);
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check32("target_pc", if_id_pc, 32'h40);

        // Misaligned redirect coinciding with a hit
        cycle(1'b1, 1'b1, 1'b1, 32'h101, 1'b0);
        check32("redirect_align", imemaddr, 32'h100);

        // Decode stall with a returned word parked in the skid buffer
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        check32("hold_ren", {31'd0, imemREN}, 32'd0);
        check32("hold_ifid_pc", if_id_pc, 32'h100);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        check32("hold_ren2", {31'd0, imemREN}, 32'd0);
        check32("hold_ifid_instr", if_id_instr, mem_word(32'h100));
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        check32("hold_release_pc", if_id_pc, 32'h104);
        check32("hold_release_addr", imemaddr, 32'h108);

        // PC wrap-around at the top of the address space
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check32("wrap_addr", imemaddr, 32'h4);

        // Randomized misses, stalls and redirects
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                               : 32'($urandom());
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 6, tgt, 1'b0);
        end
        check32("min_delivered", {31'd0, (n_deliv >= 300)}, 32'd1);

        // Halt beats a simultaneous redirect and is sticky
        cycle(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
        check32("halt_ren", {31'd0, imemREN}, 32'd0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, ($urandom_range(0, 1) == 1), 32'h300, 1'b0);

        RST = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        RST = 1'b0;
        check32("post_halt_addr", imemaddr, RESET_PC);
        check32("post_halt_ren", {31'd0, imemREN}, 32'd1);
        check32("post_halt_valid", {31'd0, if_id_valid}, 32'd0);

`ifdef FETCH_PERF_EN
        check32("perf_rst_fetch", fetch_count, 32'd0);
        check32("perf_rst_stall", stall_count, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        check32("perf_fetch", fetch_count, 32'd5);
        check32("perf_stall", stall_count, 32'd3);
`endif

        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
